// File: rtl/dmem_pkg.sv
// Shared constants for the CPU data-port responder: MMIO offsets,
// STATUS bit layout and the tohost state encoding.
package dmem_pkg;

  localparam logic [11:0] TOHOST_OFF  = 12'h000;
  localparam logic [11:0] CONSOLE_OFF = 12'h004;
  localparam logic [11:0] STATUS_OFF  = 12'h008;
  localparam logic [11:0] CYCLE_OFF   = 12'h00C;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_COUNT_LSB = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } tohost_state_t;

endpackage

// File: rtl/console_fifo.sv
// First-word-fall-through byte FIFO for the console. Pointer and count
// logic only; the parent must never push while full unless it also pops.
module console_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [7:0]                    push_data,
  input  logic                          pop,
  output logic [7:0]                    head,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;

  // Storage is not reset; stale bytes are hidden by the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(FIFO_DEPTH));
  assign count = cnt;

endmodule

// File: rtl/dmem_responder.sv
// Target end of the CPU data port: byte-writable RAM with zero-latency
// read, plus an MMIO page holding tohost, console FIFO and cycle counter.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_wdata,
  input  logic [3:0]  d_mem_wen,
  output logic [31:0] d_mem_rdata,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        test_done,
  output logic [30:0] test_code,
  output logic [15:0] con_overflow
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] ram_idx;
  logic          is_mmio;
  logic [11:0]   off;
  logic          unused_addr;

  tohost_state_t state_q, state_d;
  logic          done_set;
  logic [30:0]   code_q;
  logic [31:0]   cyc_q;
  logic [15:0]   ovf_q;

  logic          push_req, push_ok, pop;
  logic          f_empty, f_full;
  logic [CW-1:0] f_count;

  assign is_mmio     = (d_mem_addr[31:12] == MMIO_BASE[31:12]);
  assign off         = {d_mem_addr[11:2], 2'b00};
  assign ram_idx     = d_mem_addr[AW+1:2];
  assign unused_addr = ^d_mem_addr[1:0];

  // RAM lane writes; deliberately not gated by rst so a coincident write lands.
  always_ff @(posedge clk) begin
    if (!is_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (d_mem_wen[i]) ram[ram_idx][8*i +: 8] <= d_mem_wdata[8*i +: 8];
      end
    end
  end

  // Tohost state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Tohost next state: only a done-flagged write in RUN moves to DONE.
  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (is_mmio && off == TOHOST_OFF && |d_mem_wen && d_mem_wdata[0]) begin
          state_d  = ST_DONE;
          done_set = 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  // Test code is captured once, on the RUN->DONE transition.
  always_ff @(posedge clk) begin
    if (rst)           code_q <= '0;
    else if (done_set) code_q <= d_mem_wdata[31:1];
  end

  // Cycle counter freezes at the value seen by the done-writing cycle.
  always_ff @(posedge clk) begin
    if (rst)                                cyc_q <= '0;
    else if (state_q == ST_RUN && !done_set) cyc_q <= cyc_q + 32'd1;
  end

  // Console handshake: a push into a full FIFO only succeeds with a pop.
  assign pop      = !f_empty && con_ready;
  assign push_req = is_mmio && off == CONSOLE_OFF && d_mem_wen[0];
  assign push_ok  = push_req && (!f_full || pop);

  console_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok),
    .push_data (d_mem_wdata[7:0]),
    .pop       (pop),
    .head      (con_data),
    .empty     (f_empty),
    .full      (f_full),
    .count     (f_count)
  );

  // Dropped-byte counter, saturating.
  always_ff @(posedge clk) begin
    if (rst)                                                 ovf_q <= '0;
    else if (push_req && !push_ok && ovf_q != 16'hFFFF)      ovf_q <= ovf_q + 16'd1;
  end

  // Read mux: RAM is combinational; MMIO offsets decode to status views.
  always_comb begin
    d_mem_rdata = '0;
    if (!is_mmio) begin
      d_mem_rdata = ram[ram_idx];
    end else begin
      case (off)
        TOHOST_OFF: d_mem_rdata = {code_q, state_q == ST_DONE};
        STATUS_OFF: begin
          d_mem_rdata                 = 32'(f_count) << STAT_COUNT_LSB;
          d_mem_rdata[STAT_FULL_BIT]  = f_full;
          d_mem_rdata[STAT_EMPTY_BIT] = f_empty;
        end
        CYCLE_OFF:  d_mem_rdata = cyc_q;
        default:    d_mem_rdata = '0;
      endcase
    end
  end

  assign con_valid    = !f_empty;
  assign test_done    = (state_q == ST_DONE);
  assign test_code    = code_q;
  assign con_overflow = ovf_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a queue/array reference model
// compared every cycle, plus literal expectations at key points.
module tb_dmem_responder;
  logic        clk, rst;
  logic [31:0] d_mem_addr, d_mem_wdata, d_mem_rdata;
  logic [3:0]  d_mem_wen;
  logic [7:0]  con_data;
  logic        con_valid, con_ready, test_done;
  logic [30:0] test_code;
  logic [15:0] con_overflow;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .FIFO_DEPTH(8), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk(clk), .rst(rst), .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_wen(d_mem_wen), .d_mem_rdata(d_mem_rdata), .con_data(con_data),
    .con_valid(con_valid), .con_ready(con_ready), .test_done(test_done),
    .test_code(test_code), .con_overflow(con_overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mram [1024];
  bit          mknown [1024];
  logic [7:0]  mq [$];
  bit          mdone = 0;
  logic [30:0] mcode = 0;
  logic [31:0] mcyc = 0;
  logic [15:0] movf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mm(input logic [31:0] a);
    return a[31:12] == 20'hFFFF0;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [11:0] o;
    o = {a[11:2], 2'b00};
    if (!is_mm(a)) return mram[a[11:2]];
    case (o)
      12'h000: return {mcode, mdone};
      12'h008: return (32'(mq.size()) * 16) | ((mq.size() == 8) ? 32'd2 : 32'd0)
                      | ((mq.size() == 0) ? 32'd1 : 32'd0);
      12'h00C: return mcyc;
      default: return 32'd0;
    endcase
  endfunction

  // Model update from the inputs presented at each rising edge.
  always @(posedge clk) begin
    automatic bit          mm  = is_mm(d_mem_addr);
    automatic logic [11:0] o   = {d_mem_addr[11:2], 2'b00};
    automatic int          idx = int'(d_mem_addr[11:2]);
    automatic bit          pp  = (mq.size() != 0) && con_ready;
    if (!mm) begin
      for (int i = 0; i < 4; i++)
        if (d_mem_wen[i]) mram[idx][8*i +: 8] = d_mem_wdata[8*i +: 8];
      if (d_mem_wen == 4'hF) mknown[idx] = 1;
    end
    if (rst) begin
      mdone = 0; mcode = 0; mcyc = 0; movf = 0; mq.delete();
    end else begin
      if (!mdone) begin
        if (mm && o == 12'h000 && d_mem_wen != 0 && d_mem_wdata[0]) begin
          mdone = 1; mcode = d_mem_wdata[31:1];
        end else mcyc = mcyc + 1;
      end
      if (pp) void'(mq.pop_front());
      if (mm && o == 12'h004 && d_mem_wen[0]) begin
        if (mq.size() < 8) mq.push_back(d_mem_wdata[7:0]);
        else if (movf != 16'hFFFF) movf = movf + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_con_valid", {31'b0, con_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) check("m_con_data", {24'b0, con_data}, {24'b0, mq[0]});
      check("m_test_done", {31'b0, test_done}, {31'b0, mdone});
      check("m_test_code", {1'b0, test_code}, {1'b0, mcode});
      check("m_overflow", {16'b0, con_overflow}, {16'b0, movf});
      if (is_mm(d_mem_addr) || mknown[d_mem_addr[11:2]])
        check("m_rdata", d_mem_rdata, mread(d_mem_addr));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    d_mem_addr = a; d_mem_wdata = d; d_mem_wen = w;
    step();
    d_mem_wen = 4'h0;
  endtask

  logic [31:0] frozen;

  initial begin
    for (int i = 0; i < 1024; i++) mknown[i] = 0;
    rst = 1; d_mem_addr = 32'hFFFF_000C; d_mem_wdata = 0; d_mem_wen = 0; con_ready = 0;
    repeat (2) step();
    @(negedge clk);
    check("rst_done", {31'b0, test_done}, 32'd0);
    check("rst_valid", {31'b0, con_valid}, 32'd0);
    check("rst_ovf", {16'b0, con_overflow}, 32'd0);
    check("rst_cycle", d_mem_rdata, 32'd0);
    chk_en = 1;
    #1 rst = 0;

    // Byte lanes and wrap
    wr(32'h100, 32'hAABBCCDD, 4'hF);
    wr(32'h100, 32'h00001122, 4'h3);
    d_mem_addr = 32'h100;
    @(negedge clk);
    check("ram_lanes", d_mem_rdata, 32'hAABB1122);
    #1 d_mem_addr = 32'h1100;
    #1 check("ram_wrap", d_mem_rdata, 32'hAABB1122);
    wr(32'h200, 32'h55555555, 4'hF);
    d_mem_addr = 32'h200; d_mem_wdata = 32'h66666666; d_mem_wen = 4'hF;
    @(negedge clk);
    check("ram_rd_old", d_mem_rdata, 32'h55555555);
    step(); d_mem_wen = 0;
    @(negedge clk);
    check("ram_rd_new", d_mem_rdata, 32'h66666666);

    // Unmapped MMIO
    #1 wr(32'hFFFF_0010, 32'hFFFFFFFF, 4'hF);
    d_mem_addr = 32'hFFFF_0010;
    @(negedge clk);
    check("unmapped_rd", d_mem_rdata, 32'd0);
    check("unmapped_done", {31'b0, test_done}, 32'd0);
    check("unmapped_valid", {31'b0, con_valid}, 32'd0);

    // Console ordering
    #1 wr(32'hFFFF_0004, 32'h48, 4'h1);
    wr(32'hFFFF_0004, 32'h69, 4'h1);
    wr(32'hFFFF_0004, 32'h21, 4'h1);
    wr(32'hFFFF_0004, 32'h77, 4'h0);
    @(negedge clk);
    check("con_h", {24'b0, con_data}, 32'h48);
    #1 con_ready = 1;
    step(); @(negedge clk);
    check("con_i", {24'b0, con_data}, 32'h69);
    step(); @(negedge clk);
    check("con_bang", {24'b0, con_data}, 32'h21);
    step(); @(negedge clk);
    check("con_drained", {31'b0, con_valid}, 32'd0);
    #1 con_ready = 0;

    // Overflow
    for (int i = 0; i < 10; i++) wr(32'hFFFF_0004, i, 4'h1);
    d_mem_addr = 32'hFFFF_0008;
    @(negedge clk);
    check("ovf_status", d_mem_rdata, 32'h82);
    check("ovf_count", {16'b0, con_overflow}, 32'd2);
    #1 d_mem_addr = 32'hFFFF_0004; d_mem_wdata = 32'hEE; d_mem_wen = 4'h1; con_ready = 1;
    step();
    d_mem_wen = 0; con_ready = 0; d_mem_addr = 32'hFFFF_0008;
    @(negedge clk);
    check("full_pushpop_status", d_mem_rdata, 32'h82);
    check("full_pushpop_ovf", {16'b0, con_overflow}, 32'd2);
    check("full_pushpop_head", {24'b0, con_data}, 32'h01);
    #1 con_ready = 1;
    repeat (3) step();
    con_ready = 0;
    @(negedge clk);
    check("five_left_head", {24'b0, con_data}, 32'h04);

    // Tohost
    #1 wr(32'hFFFF_0000, 32'h1, 4'hF);
    @(negedge clk);
    check("tohost_done", {31'b0, test_done}, 32'd1);
    check("tohost_code", {1'b0, test_code}, 32'd0);
    #1 wr(32'hFFFF_0000, 32'hC9, 4'hF);
    @(negedge clk);
    check("tohost_ignored", {1'b0, test_code}, 32'd0);
    #1 d_mem_addr = 32'hFFFF_000C;
    @(negedge clk);
    frozen = mcyc;
    #1 repeat (10) step();
    @(negedge clk);
    check("cycle_frozen", d_mem_rdata, frozen);

    // Reset mid-run, with a coincident RAM write
    #1 d_mem_addr = 32'h300; d_mem_wdata = 32'hCAFEF00D; d_mem_wen = 4'hF; rst = 1;
    step();
    rst = 0; d_mem_wen = 0; d_mem_addr = 32'hFFFF_000C;
    @(negedge clk);
    check("rst2_valid", {31'b0, con_valid}, 32'd0);
    check("rst2_done", {31'b0, test_done}, 32'd0);
    check("rst2_ovf", {16'b0, con_overflow}, 32'd0);
    check("rst2_cycle0", d_mem_rdata, 32'd0);
    step();
    @(negedge clk);
    check("rst2_cycle1", d_mem_rdata, 32'd1);
    #1 d_mem_addr = 32'h100;
    #1 check("rst2_ram_kept", d_mem_rdata, 32'hAABB1122);
    d_mem_addr = 32'h300;
    #1 check("rst2_ram_written", d_mem_rdata, 32'hCAFEF00D);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
